// File: rtl/sort_pkg.sv
// Shared constants, state encoding and width helpers for the bubble-down sorter.
package sort_pkg;

    localparam int N_DEF = 7;
    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of an element index; at least one bit even for a single-element block.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width needed to count up to n*(n-1)/2 exchanges.
    function automatic int sc_width(input int n);
        int pairs;
        pairs = n * (n - 1) / 2;
        return (pairs > 0) ? $clog2(pairs + 1) : 1;
    endfunction

endpackage

// File: rtl/cmp_xchg.sv
// Compare-exchange cell: orders an adjacent pair, leaving equal values in place.
module cmp_xchg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swapped
);

    assign swapped = (b < a);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/bubble_down_sorter.sv
// Block sorter: one compare-exchange per cycle, each pass sinking the minimum of
// the unsorted region towards index p. Early exit on a pass with no exchange.
//
// state | meaning
// IDLE  | in_ready high, waiting for a block
// PASS  | one compare-exchange on (j-1, j) per cycle
// DONE  | out_valid high, sorted block held until taken
module bubble_down_sorter
    import sort_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*W-1:0]           in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*W-1:0]           out_data,
    output logic [sc_width(N)-1:0]   swap_count
);

    localparam int IW  = idx_width(N);
    localparam int SCW = sc_width(N);

    state_t          state_q;
    logic [W-1:0]    elem_q [N];
    logic [IW-1:0]   p_q;
    logic [IW-1:0]   j_q;
    logic            swapped_q;
    logic [SCW-1:0]  swap_count_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [W-1:0]    cmp_a;
    logic [W-1:0]    cmp_b;
    logic [W-1:0]    cmp_lo;
    logic [W-1:0]    cmp_hi;
    logic            cmp_swap;
    logic            pass_swapped;
    logic            last_cmp;
    logic            finish;

    always_comb begin
        cmp_a = '0;
        cmp_b = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(j_q) == i + 1) cmp_a = elem_q[i];
            if (int'(j_q) == i)     cmp_b = elem_q[i];
        end
    end

    cmp_xchg #(.W(W)) u_cmp_xchg (
        .a       (cmp_a),
        .b       (cmp_b),
        .lo      (cmp_lo),
        .hi      (cmp_hi),
        .swapped (cmp_swap)
    );

    // The flag seen at end of pass must include this cycle's exchange.
    assign pass_swapped = swapped_q | cmp_swap;
    assign last_cmp     = (int'(j_q) == int'(p_q) + 1);
    assign finish       = !pass_swapped || (int'(p_q) == N - 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < N; i++) elem_q[i] <= '0;
            p_q          <= '0;
            j_q          <= IW'(N - 1);
            swapped_q    <= 1'b0;
            swap_count_q <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N; i++) elem_q[i] <= in_data[W*i +: W];
                        p_q          <= '0;
                        j_q          <= IW'(N - 1);
                        swapped_q    <= 1'b0;
                        swap_count_q <= '0;
                        in_ready_q   <= 1'b0;
                        if (N < 2) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q     <= PASS;
                        end
                    end
                end
                PASS: begin
                    if (cmp_swap) begin
                        for (int i = 0; i < N; i++) begin
                            if (int'(j_q) == i + 1) elem_q[i] <= cmp_lo;
                            if (int'(j_q) == i)     elem_q[i] <= cmp_hi;
                        end
                        swap_count_q <= swap_count_q + 1'b1;
                    end
                    if (last_cmp) begin
                        if (finish) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            swapped_q   <= pass_swapped;
                        end else begin
                            p_q       <= p_q + 1'b1;
                            j_q       <= IW'(N - 1);
                            swapped_q <= 1'b0;
                        end
                    end else begin
                        j_q       <= j_q - 1'b1;
                        swapped_q <= pass_swapped;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) out_data[W*i +: W] = elem_q[i];
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign swap_count = swap_count_q;

endmodule

// File: doc/bubble_down_sorter.md
BUBBLE_DOWN_SORTER -- requirements
Module: bubble_down_sorter

Interface
REQ-001 The module SHALL have parameter N, default 7, giving the number of elements per block.
REQ-002 The module SHALL have parameter W, default 8, giving the element width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit: an unsorted block is offered.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the sorter accepts a block this cycle.
REQ-007 The module SHALL have port in_data, input, N*W bits: element i occupies bits [W*i+W-1 : W*i], unsigned.
REQ-008 The module SHALL have port out_valid, output, 1 bit: a sorted block is presented.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the consumer takes the block this cycle.
REQ-010 The module SHALL have port out_data, output, N*W bits: sorted block, same packing as in_data; element 0 is the smallest.
REQ-011 The module SHALL have port swap_count, output, ceil(log2(N*(N-1)/2+1)) bits (5 for N=7): number of exchanges performed on the current block.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, PASS and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; no second block is accepted until the current block leaves.
REQ-014 IDLE SHALL transition to PASS when in_valid and in_ready are both 1 at an edge. That edge loads in_data into the element registers, sets pass p=0, sets index j=N-1, clears the swapped flag and clears swap_count.
REQ-015 Each PASS cycle SHALL perform exactly one compare-exchange on elements j-1 and j.
  - Swap when elem[j] < elem[j-1], strictly; equal values are not swapped (stable).
  - Each swap increments swap_count and sets the swapped flag.
REQ-016 Within a pass, j SHALL descend from N-1 to p+1, so the minimum of the unsorted region sinks to index p. This is the opposite direction to the ascending max-bubbling chain.
REQ-017 At the end of a pass (j=p+1 compared), the FSM SHALL enter DONE if the swapped flag is 0 or p=N-2. Otherwise it SHALL increment p, reset j to N-1 and clear the swapped flag.
REQ-018 The swapped flag SHALL include the swap made on the last compare of the pass.
REQ-019 Latency SHALL be as follows: with k the total number of compares, out_valid rises in the cycle after the k-th compare edge.
  - k ranges from N-1 (already sorted) to N(N-1)/2 (21 for N=7).
REQ-020 In DONE, out_data and swap_count SHALL hold stable until out_valid and out_ready are both 1 at an edge. The FSM then returns to IDLE, and in_ready is 1 in the next cycle.
REQ-021 in_valid while not in IDLE SHALL be ignored, and in_data changes SHALL have no effect after acceptance.
REQ-022 N=1 SHALL go from acceptance directly to DONE with zero compares; N=2 SHALL perform exactly one compare.

Reset
REQ-023 When rst=1 at an edge, the FSM SHALL go to IDLE from any state, including mid-PASS and DONE; any partially sorted block is discarded.
REQ-024 After reset, in_ready SHALL be 1, out_valid 0, out_data all zeros, swap_count 0, p 0, j N-1 and the swapped flag 0.
REQ-025 rst SHALL take priority over any simultaneous in or out handshake.

Structure
REQ-026 Package sort_pkg SHALL hold the default N and W constants and the state enum typedef (IDLE, PASS, DONE).
REQ-027 A combinational sub-module cmp_xchg (inputs a, b; outputs lo, hi, swapped) SHALL be instantiated once and muxed onto positions j-1 and j.
REQ-028 No combinational path SHALL exist from in_valid or out_ready to any output other than through registered state.

Verification
REQ-029 The bench SHALL apply input 01,02,03,04,05,06,07 (element0 first) and check out_data identical, swap_count=0, and out_valid 6 cycles after acceptance.
REQ-030 The bench SHALL apply input 07,06,05,04,03,02,01 and check out_data 01..07, swap_count=21, and out_valid 21 cycles after acceptance.
REQ-031 The bench SHALL apply input 05,05,FF,00,05,00,FF and check out_data 00,00,05,05,05,FF,FF with unsigned compare (FF greatest).
REQ-032 The bench SHALL hold out_ready=0 for 10 cycles in DONE and check out_valid stays 1, out_data is stable and in_ready stays 0. When out_ready=1, the bench SHALL check in_ready=1 the next cycle.
REQ-033 The bench SHALL assert rst for 1 cycle during the 10th compare of the reverse-sorted block and check the reset values next cycle. It SHALL then apply a new block 03,01,02,00,00,00,00 and check it sorts to 00,00,00,00,01,02,03.
REQ-034 The bench SHALL toggle in_valid and change in_data throughout PASS and check the result of the accepted block is unaffected.
